mem_lock_arbiter: RTL
=====================

MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 Parameter NCORES, default 4, number of attached cores (2..8).
REQ-002 Parameter AW, default 16, memory address width.
REQ-003 Parameter DW, default 16, memory data width.
REQ-004 Parameter NLOCKS, default 16, number of hardware locks; lock address width is clog2(NLOCKS).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 read_request  in  NCORES  per-core read request, level, held until mem_ac.
REQ-008 write_request  in  NCORES  per-core write request, level, held until mem_ac.
REQ-009 read_adr, write_adr  in  NCORES x AW  per-core addresses.
REQ-010 write_dat  in  NCORES x DW  per-core write data.
REQ-011 mem_ac  out  NCORES  one-cycle acknowledge to the granted core.
REQ-012 mem_dat  out  DW  read data, broadcast, valid when mem_ac asserted for a read.
REQ-013 lock_adr  in  NCORES x clog2(NLOCKS); lock_en, unlock_en  in  NCORES.
REQ-014 lock_ac  out  NCORES  per-core lock acknowledge.
REQ-015 ram_adr  out  AW; ram_wdat  out  DW; ram_we  out  1; ram_rdat  in  DW; single-port RAM with synchronous read, 1-cycle latency.

Function
REQ-016 Arbiter FSM states: IDLE, ISSUE, DONE.
REQ-017 IDLE: when any request is set, select grant g round-robin starting at rr_ptr, latch g, op and address/data; go to ISSUE. With no request, stay in IDLE.
REQ-018 ISSUE: drive ram_adr/ram_wdat from latched values; ram_we = 1 only for a write; go to DONE.
REQ-019 DONE: mem_ac[g] = 1 for exactly this cycle; for a read, mem_dat = ram_rdat; rr_ptr <= (g+1) mod NCORES; go to IDLE.
REQ-020 Latency: request sampled in cycle 0, ram access in cycle 1, mem_ac in cycle 2; peak throughput one access per 3 cycles.
REQ-021 When one core asserts read and write simultaneously, the write is serviced first; the read remains pending for a later grant.
REQ-022 Requests that are still high in the IDLE cycle after mem_ac are treated as new requests.
REQ-023 Outside ISSUE, ram_we = 0; mem_ac is never asserted to more than one core.
REQ-024 Lock table: NLOCKS entries of {held, owner}; the table is updated once per cycle.
REQ-025 Unlock: unlock_en[i] clears entry lock_adr[i] only when held and owner == i; all other unlocks are ignored.
REQ-026 Lock: lock_en[i] succeeds when the entry is free or owned by i (re-entrant, no change); among requests for one free entry in the same cycle, the lowest core index wins.
REQ-027 Ordering: unlocks in a cycle apply before locks in the same cycle.
REQ-028 lock_ac is registered: lock_ac[i] = 1 in the cycle after lock_en[i] is sampled iff core i owns the entry after that update; otherwise 0.
REQ-029 Locks and memory arbitration are independent; holding a lock gives no memory priority.

Reset
REQ-030 While reset is low: FSM = IDLE, rr_ptr = 0, all lock entries free; mem_ac, lock_ac, ram_we = 0; mem_dat, ram_adr, ram_wdat = 0.
REQ-031 Reset asserted mid-access aborts the access; no mem_ac is issued for it, and a write in ISSUE is suppressed because ram_we goes 0 immediately.

Structure
REQ-032 Shared package core_pkg holds arb_state_t (IDLE/ISSUE/DONE) and the default NCORES/NLOCKS constants.
REQ-033 Lock table is a sub-module lock_table(NCORES, NLOCKS); the arbiter FSM lives in mem_lock_arbiter.

Verification
REQ-034 Core 1 reads 0x0040 (RAM holds 0xBEEF) -> mem_ac[1] = 1 two cycles later with mem_dat = 0xBEEF.
REQ-035 All 4 cores request at once, rr_ptr = 0 -> grants in order 0, 1, 2, 3; mem_ac pulses 3 cycles apart.
REQ-036 Core 2 asserts read and write to 0x0010 (wdat 0x1234) together -> the write is acked first; the following read of core 2 returns 0x1234.
REQ-037 Cores 0 and 3 lock entry 5 in the same cycle -> lock_ac = 0b0001; core 0 unlocks while core 3 re-locks in the same cycle -> lock_ac = 0b1000.
REQ-038 Core 1 unlocks entry 5 owned by core 0 -> ignored; core 2 then locks entry 5 -> lock_ac[2] = 0.
REQ-039 Reset pulsed low during ISSUE of a write to 0x0020 -> RAM unchanged, no mem_ac, FSM returns to IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the memory/lock arbiter slice.
// Contents:
//   DEFAULT_NCORES / DEFAULT_NLOCKS / DEFAULT_AW / DEFAULT_DW - default sizing
//   arb_state_t - memory arbiter FSM state encoding (IDLE, ISSUE, DONE)
//   rr_pick     - round-robin selection helper (up to 8 requesters)
package core_pkg;

    localparam int DEFAULT_NCORES = 4;
    localparam int DEFAULT_NLOCKS = 16;
    localparam int DEFAULT_AW     = 16;
    localparam int DEFAULT_DW     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Returns the first requester found when scanning upward from 'start',
    // wrapping at n. The scan runs from the far end back toward 'start' so
    // that the last hit, which is the one closest to 'start', wins. With no
    // request at all the result is 'start' and the caller must ignore it.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] start,
        input int         n
    );
        logic [2:0] pick;
        int         idx;
        pick = start;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % n;
            if (req[idx[2:0]]) begin
                pick = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_lock_arbiter_if.sv
// Bus bundle between the cores, the arbiter and the single-port RAM.
// Signals:
//   read_request/write_request [NCORES]  level requests, held until mem_ac
//   read_adr/write_adr [NCORES][AW]      per-core addresses
//   write_dat [NCORES][DW]               per-core write data
//   mem_ac [NCORES], mem_dat [DW]        one-cycle acknowledge, read data
//   lock_adr [NCORES][clog2(NLOCKS)], lock_en, unlock_en, lock_ac [NCORES]
//   ram_adr, ram_wdat, ram_we, ram_rdat  RAM port (synchronous read)
// Modports:
//   slave  - the arbiter side
//   master - the core/RAM environment side
interface mem_lock_arbiter_if
    import core_pkg::*;
#(
    parameter int NCORES = DEFAULT_NCORES,
    parameter int AW     = DEFAULT_AW,
    parameter int DW     = DEFAULT_DW,
    parameter int NLOCKS = DEFAULT_NLOCKS
);

    localparam int LW = $clog2(NLOCKS);

    logic [NCORES-1:0]         read_request;
    logic [NCORES-1:0]         write_request;
    logic [NCORES-1:0][AW-1:0] read_adr;
    logic [NCORES-1:0][AW-1:0] write_adr;
    logic [NCORES-1:0][DW-1:0] write_dat;
    logic [NCORES-1:0]         mem_ac;
    logic [DW-1:0]             mem_dat;

    logic [NCORES-1:0][LW-1:0] lock_adr;
    logic [NCORES-1:0]         lock_en;
    logic [NCORES-1:0]         unlock_en;
    logic [NCORES-1:0]         lock_ac;

    logic [AW-1:0]             ram_adr;
    logic [DW-1:0]             ram_wdat;
    logic                      ram_we;
    logic [DW-1:0]             ram_rdat;

    modport slave (
        input  read_request, write_request, read_adr, write_adr, write_dat,
        output mem_ac, mem_dat,
        input  lock_adr, lock_en, unlock_en,
        output lock_ac,
        output ram_adr, ram_wdat, ram_we,
        input  ram_rdat
    );

    modport master (
        output read_request, write_request, read_adr, write_adr, write_dat,
        input  mem_ac, mem_dat,
        output lock_adr, lock_en, unlock_en,
        input  lock_ac,
        input  ram_adr, ram_wdat, ram_we,
        output ram_rdat
    );

endinterface

// File: rtl/lock_table.sv
// Hardware lock table shared by all cores.
// Each of the NLOCKS entries holds {held, owner}. Per cycle, all unlocks are
// applied first, then locks in ascending core order, so the lowest core index
// wins a contested free entry. lock_ac is registered and reports ownership
// after the update for every core that asked for a lock.
// Ports:
//   clk, reset (async, active-low)
//   lock_adr [NCORES][clog2(NLOCKS)]  entry addressed by each core
//   lock_en, unlock_en [NCORES]       per-core lock / unlock strobes
//   lock_ac [NCORES]                  registered lock acknowledge
module lock_table
    import core_pkg::*;
#(
    parameter int NCORES = DEFAULT_NCORES,
    parameter int NLOCKS = DEFAULT_NLOCKS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NCORES-1:0][$clog2(NLOCKS)-1:0] lock_adr,
    input  logic [NCORES-1:0]                     lock_en,
    input  logic [NCORES-1:0]                     unlock_en,
    output logic [NCORES-1:0]                     lock_ac
);

    localparam int OW = $clog2(NCORES);

    logic [NLOCKS-1:0]         held;
    logic [NLOCKS-1:0]         held_next;
    logic [NLOCKS-1:0][OW-1:0] owner;
    logic [NLOCKS-1:0][OW-1:0] owner_next;
    logic [NCORES-1:0]         ac_next;

    // Next table contents. The loops are sequential in meaning: unlocks see
    // the current table, locks see the table after all unlocks, and a lock
    // granted to a lower core is visible to the higher cores that follow.
    // A freed entry keeps its stale owner; only 'held' is meaningful.
    always_comb begin
        held_next  = held;
        owner_next = owner;
        ac_next    = '0;

        for (int i = 0; i < NCORES; i++) begin
            if (unlock_en[i] && held_next[lock_adr[i]] &&
                owner_next[lock_adr[i]] == OW'(i)) begin
                held_next[lock_adr[i]] = 1'b0;
            end
        end

        for (int i = 0; i < NCORES; i++) begin
            if (lock_en[i] && !held_next[lock_adr[i]]) begin
                held_next[lock_adr[i]]  = 1'b1;
                owner_next[lock_adr[i]] = OW'(i);
            end
        end

        for (int i = 0; i < NCORES; i++) begin
            ac_next[i] = lock_en[i] && held_next[lock_adr[i]] &&
                         owner_next[lock_adr[i]] == OW'(i);
        end
    end

    // Table and acknowledge registers; reset frees every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held    <= '0;
            owner   <= '0;
            lock_ac <= '0;
        end else begin
            held    <= held_next;
            owner   <= owner_next;
            lock_ac <= ac_next;
        end
    end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Round-robin arbiter giving NCORES cores access to one single-port RAM with
// a synchronous 1-cycle read, plus a lock table for software mutual exclusion.
// An access takes three cycles: IDLE samples the requests and latches the
// winner, ISSUE drives the RAM, DONE pulses mem_ac and returns read data.
// A core raising read and write together is served the write first.
// Ports:
//   clk             single clock, rising edge
//   reset           asynchronous, active-low
//   bus (slave)     request/ack, lock and RAM signals (see mem_lock_arbiter_if)
module mem_lock_arbiter
    import core_pkg::*;
#(
    parameter int NCORES = DEFAULT_NCORES,
    parameter int AW     = DEFAULT_AW,
    parameter int DW     = DEFAULT_DW,
    parameter int NLOCKS = DEFAULT_NLOCKS
) (
    input  logic              clk,
    input  logic              reset,
    mem_lock_arbiter_if.slave bus
);

    localparam int PW = $clog2(NCORES);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              capture;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant;
    logic              op_write;
    logic [AW-1:0]     lat_adr;
    logic [DW-1:0]     lat_wdat;

    logic [NCORES-1:0] any_req;
    logic [PW-1:0]     pick;

    logic [NCORES-1:0] ack;
    logic [DW-1:0]     rdat_out;
    logic [AW-1:0]     ram_adr_out;
    logic [DW-1:0]     ram_wdat_out;
    logic              ram_we_out;

    assign any_req = bus.read_request | bus.write_request;
    assign pick    = PW'(rr_pick(8'(any_req), 3'(rr_ptr), NCORES));

    // State register. Reset drops straight to IDLE, which also kills any
    // ram_we of an access that was in ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all arbiter outputs. RAM address/data are forced to
    // zero outside ISSUE so the port is quiet when no access is in flight.
    always_comb begin
        state_next   = state;
        capture      = 1'b0;
        ack          = '0;
        rdat_out     = '0;
        ram_adr_out  = '0;
        ram_wdat_out = '0;
        ram_we_out   = 1'b0;

        case (state)
            IDLE: begin
                if (|any_req) begin
                    capture    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                ram_adr_out = lat_adr;
                if (op_write) begin
                    ram_we_out   = 1'b1;
                    ram_wdat_out = lat_wdat;
                end
                state_next = DONE;
            end
            DONE: begin
                ack[grant] = 1'b1;
                if (!op_write) begin
                    rdat_out = bus.ram_rdat;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction latch and round-robin pointer. The pointer moves to the
    // core after the one just served, so it advances only when an access
    // actually completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant    <= '0;
            op_write <= 1'b0;
            lat_adr  <= '0;
            lat_wdat <= '0;
            rr_ptr   <= '0;
        end else begin
            if (capture) begin
                grant    <= pick;
                op_write <= bus.write_request[pick];
                lat_adr  <= bus.write_request[pick] ? bus.write_adr[pick]
                                                    : bus.read_adr[pick];
                lat_wdat <= bus.write_dat[pick];
            end
            if (state == DONE) begin
                rr_ptr <= (grant == PW'(NCORES - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign bus.mem_ac   = ack;
    assign bus.mem_dat  = rdat_out;
    assign bus.ram_adr  = ram_adr_out;
    assign bus.ram_wdat = ram_wdat_out;
    assign bus.ram_we   = ram_we_out;

    // Locks are completely independent of memory arbitration.
    lock_table #(
        .NCORES (NCORES),
        .NLOCKS (NLOCKS)
    ) u_lock_table (
        .clk       (clk),
        .reset     (reset),
        .lock_adr  (bus.lock_adr),
        .lock_en   (bus.lock_en),
        .unlock_en (bus.unlock_en),
        .lock_ac   (bus.lock_ac)
    );

endmodule
